// File: rtl/dmem_sensor_bridge.sv
// dmem_sensor_bridge: data SRAM plus memory-mapped sensor FIFO behind the core dmem port; SENSOR_ALERT_EN adds the threshold alert
module dmem_sensor_bridge #(
  parameter int MEM_WORDS  = 128,
  parameter int FIFO_DEPTH = 8,
  parameter int SENSOR_W   = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                dmem_en,
  input  logic                dmem_we,
  input  logic [31:0]         dmem_addr,
  input  logic [31:0]         dmem_wdata,
  output logic [31:0]         dmem_rdata,
  input  logic                sensor_valid,
  output logic                sensor_ready,
  input  logic [SENSOR_W-1:0] sensor_data,
  output logic                alert
);
  localparam int AW = $clog2(MEM_WORDS);
  localparam int PW = $clog2(FIFO_DEPTH);
  logic [31:0] mem_q [MEM_WORDS];
  logic [SENSOR_W-1:0] fifo_q [FIFO_DEPTH];
  logic [PW:0] wr_q, wr_d, rd_q, rd_d, cnt;
  logic [31:0] rdata_q, rdata_d, status, thr_rd;
  logic ovf_q, ovf_d, alert_q;
  logic [AW-1:0] idx;
  logic [1:0] reg_sel;
  logic mmio_rd, mmio_wr, push, pop, full, empty, stat_wr;
  logic unused_addr;
  assign idx = dmem_addr[AW+1:2];
  assign reg_sel = dmem_addr[3:2];
  assign mmio_rd = dmem_en & ~dmem_we & dmem_addr[31];
  assign mmio_wr = dmem_en & dmem_we & dmem_addr[31];
  assign stat_wr = mmio_wr & (reg_sel == 2'd1);
  assign cnt = wr_q - rd_q;
  assign full = cnt[PW];
  assign empty = (cnt == '0);
  assign push = sensor_valid & ~full;
  assign pop = mmio_rd & (reg_sel == 2'd0) & ~empty;
  assign status = {20'b0, alert_q, ovf_q, full, empty, 8'(cnt)};
  assign sensor_ready = ~full;
  assign dmem_rdata = rdata_q;
  assign alert = alert_q;
  assign unused_addr = ^{dmem_addr[30:AW+2], dmem_addr[1:0]};
`ifdef SENSOR_ALERT_EN
  logic [SENSOR_W-1:0] thresh_q, thresh_d;
  logic alert_d;
  assign thr_rd = 32'(thresh_q);
  // threshold register and sticky alert; a same-cycle set beats the clear
  always_comb begin
    thresh_d = (mmio_wr & (reg_sel == 2'd2)) ? dmem_wdata[SENSOR_W-1:0] : thresh_q;
    alert_d = (push & (sensor_data > thresh_q)) | (alert_q & ~(stat_wr & dmem_wdata[11]));
  end
  // alert state registers
  always_ff @(posedge clk) begin
    if (reset) begin
      thresh_q <= '1;
      alert_q <= 1'b0;
    end else begin
      thresh_q <= thresh_d;
      alert_q <= alert_d;
    end
  end
`else
  assign thr_rd = '0;
  assign alert_q = 1'b0;
`endif
  // read mux, FIFO pointer advance and sticky overflow; a same-cycle set beats the clear
  always_comb begin
    rdata_d = !dmem_en ? '0 :
              !dmem_addr[31] ? mem_q[idx] :
              dmem_we ? '0 :
              (reg_sel == 2'd0) ? (empty ? '0 : 32'(fifo_q[rd_q[PW-1:0]])) :
              (reg_sel == 2'd1) ? status :
              (reg_sel == 2'd2) ? thr_rd : '0;
    wr_d = wr_q + {{PW{1'b0}}, push};
    rd_d = rd_q + {{PW{1'b0}}, pop};
    ovf_d = (sensor_valid & full) | (ovf_q & ~(stat_wr & dmem_wdata[10]));
  end
  // control registers
  always_ff @(posedge clk) begin
    if (reset) begin
      rdata_q <= '0;
      wr_q <= '0;
      rd_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      rdata_q <= rdata_d;
      wr_q <= wr_d;
      rd_q <= rd_d;
      ovf_q <= ovf_d;
    end
  end
  // SRAM and FIFO storage, contents survive reset
  always_ff @(posedge clk) begin
    if (dmem_en & dmem_we & ~dmem_addr[31]) mem_q[idx] <= dmem_wdata;
    if (push) fifo_q[wr_q[PW-1:0]] <= sensor_data;
  end
endmodule

// File: tb/tb_dmem_sensor_bridge.sv
// tb_dmem_sensor_bridge: vector table, corner sequences and randomized run against a queue-based reference model
module tb_dmem_sensor_bridge;
`ifdef SENSOR_ALERT_EN
  localparam bit ALERT = 1'b1;
`else
  localparam bit ALERT = 1'b0;
`endif
  localparam logic [31:0] THR_RST = ALERT ? 32'hFFFF : 32'h0;
  logic clk, reset, dmem_en, dmem_we, sensor_valid, sensor_ready, alert;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [15:0] sensor_data;
  int n_cmp = 0, n_bad = 0;
  logic [31:0] m_mem [128];
  bit m_known [128];
  logic [15:0] m_q [$];
  bit m_ovf, m_al;
  logic [15:0] m_th;
  typedef struct {
    bit en; bit we; logic [31:0] a; logic [31:0] wd; bit sv; logic [15:0] sd; bit chk; logic [31:0] exp;
  } vec_t;
  vec_t vt [20];

  dmem_sensor_bridge dut (
    .clk(clk), .reset(reset), .dmem_en(dmem_en), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .sensor_valid(sensor_valid),
    .sensor_ready(sensor_ready), .sensor_data(sensor_data), .alert(alert)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_ovf = 1'b0;
    m_al = 1'b0;
    m_th = 16'hFFFF;
  endtask

  task automatic model(input bit en, we, input logic [31:0] a, wd, input bit sv, input logic [15:0] sd,
                       output logic [31:0] er, output bit ev);
    int n = m_q.size();
    bit full0 = (n == 8);
    bit ovf_set = 1'b0, ovf_clr = 1'b0, al_set = 1'b0, al_clr = 1'b0;
    logic [15:0] th0 = m_th;
    int idx = int'(a[8:2]);
    er = 32'h0;
    ev = 1'b1;
    if (en && !a[31]) begin
      er = m_mem[idx];
      ev = m_known[idx];
      if (we) begin
        m_mem[idx] = wd;
        m_known[idx] = 1'b1;
      end
    end else if (en && !we) begin
      case (a[3:2])
        2'd0: if (n > 0) er = {16'h0, m_q.pop_front()};
        2'd1: er = {20'h0, m_al, m_ovf, full0, n == 0, 8'(n)};
        2'd2: er = ALERT ? {16'h0, m_th} : 32'h0;
        default: er = 32'h0;
      endcase
    end else if (en) begin
      if (a[3:2] == 2'd1) begin
        ovf_clr = wd[10];
        al_clr = wd[11];
      end
      if (a[3:2] == 2'd2 && ALERT) m_th = wd[15:0];
    end
    if (sv) begin
      if (!full0) begin
        m_q.push_back(sd);
        if (ALERT && sd > th0) al_set = 1'b1;
      end else ovf_set = 1'b1;
    end
    m_ovf = ovf_set || (m_ovf && !ovf_clr);
    m_al = al_set || (m_al && !al_clr);
  endtask

  task automatic step(input bit en, we, input logic [31:0] a, wd, input bit sv, input logic [15:0] sd);
    logic [31:0] er;
    bit ev;
    dmem_en = en;
    dmem_we = we;
    dmem_addr = a;
    dmem_wdata = wd;
    sensor_valid = sv;
    sensor_data = sd;
    model(en, we, a, wd, sv, sd, er, ev);
    @(posedge clk);
    #1;
    if (ev) check("model_rdata", dmem_rdata, er);
    check("model_ready", {31'h0, sensor_ready}, {31'h0, m_q.size() < 8});
    check("model_alert", {31'h0, alert}, {31'h0, m_al});
  endtask

  task automatic do_reset(input bit en, input logic [31:0] a);
    reset = 1'b1;
    dmem_en = en;
    dmem_we = 1'b0;
    dmem_addr = a;
    dmem_wdata = 32'h0;
    sensor_valid = 1'b1;
    sensor_data = 16'hFFFF;
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
    check("rst_rdata", dmem_rdata, 32'h0);
    check("rst_ready", {31'h0, sensor_ready}, 32'h1);
    check("rst_alert", {31'h0, alert}, 32'h0);
  endtask

  initial begin
    vt[0]  = '{1'b1, 1'b1, 32'h0000_0000, 32'h8,     1'b0, 16'h0,  1'b0, 32'h0};
    vt[1]  = '{1'b1, 1'b0, 32'h0000_0000, 32'h0,     1'b0, 16'h0,  1'b1, 32'h8};
    vt[2]  = '{1'b1, 1'b0, 32'h0000_0200, 32'h0,     1'b0, 16'h0,  1'b1, 32'h8};
    vt[3]  = '{1'b1, 1'b1, 32'h0000_0010, 32'hA,     1'b0, 16'h0,  1'b0, 32'h0};
    vt[4]  = '{1'b1, 1'b1, 32'h0000_0010, 32'hB,     1'b0, 16'h0,  1'b1, 32'hA};
    vt[5]  = '{1'b1, 1'b0, 32'h0000_0010, 32'h0,     1'b0, 16'h0,  1'b1, 32'hB};
    vt[6]  = '{1'b0, 1'b0, 32'h0000_0000, 32'h0,     1'b1, 16'h11, 1'b1, 32'h0};
    vt[7]  = '{1'b0, 1'b1, 32'h0000_0010, 32'hDEAD,  1'b1, 16'h22, 1'b1, 32'h0};
    vt[8]  = '{1'b0, 1'b0, 32'h0000_0000, 32'h0,     1'b1, 16'h33, 1'b1, 32'h0};
    vt[9]  = '{1'b1, 1'b0, 32'h8000_0004, 32'h0,     1'b0, 16'h0,  1'b1, 32'h3};
    vt[10] = '{1'b1, 1'b0, 32'h8000_0000, 32'h0,     1'b0, 16'h0,  1'b1, 32'h11};
    vt[11] = '{1'b1, 1'b0, 32'h8000_0000, 32'h0,     1'b0, 16'h0,  1'b1, 32'h22};
    vt[12] = '{1'b1, 1'b0, 32'h8000_0000, 32'h0,     1'b0, 16'h0,  1'b1, 32'h33};
    vt[13] = '{1'b1, 1'b0, 32'h8000_0004, 32'h0,     1'b0, 16'h0,  1'b1, 32'h100};
    vt[14] = '{1'b1, 1'b0, 32'h8000_0000, 32'h0,     1'b0, 16'h0,  1'b1, 32'h0};
    vt[15] = '{1'b1, 1'b0, 32'h8000_000C, 32'h0,     1'b0, 16'h0,  1'b1, 32'h0};
    vt[16] = '{1'b1, 1'b1, 32'h8000_000C, 32'hFFFF_FFFF, 1'b0, 16'h0, 1'b1, 32'h0};
    vt[17] = '{1'b1, 1'b1, 32'h8000_0000, 32'h1234,  1'b0, 16'h0,  1'b1, 32'h0};
    vt[18] = '{1'b1, 1'b0, 32'h0000_0010, 32'h0,     1'b0, 16'h0,  1'b1, 32'hB};
    vt[19] = '{1'b1, 1'b0, 32'h8000_0008, 32'h0,     1'b0, 16'h0,  1'b1, THR_RST};
    for (int i = 0; i < 128; i++) m_known[i] = 1'b0;
    reset = 1'b0;
    model_reset();
    do_reset(1'b0, 32'h0);
    for (int i = 0; i < 20; i++) begin
      step(vt[i].en, vt[i].we, vt[i].a, vt[i].wd, vt[i].sv, vt[i].sd);
      if (vt[i].chk) check($sformatf("vec%0d", i), dmem_rdata, vt[i].exp);
    end
    for (int i = 0; i < 9; i++) begin
      step(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 16'(i + 1));
      if (i == 7) check("ready_full", {31'h0, sensor_ready}, 32'h0);
    end
    step(1'b1, 1'b0, 32'h8000_0004, 32'h0, 1'b0, 16'h0);
    check("ovf_status", dmem_rdata, 32'h608);
    step(1'b1, 1'b1, 32'h8000_0004, 32'h400, 1'b0, 16'h0);
    step(1'b1, 1'b0, 32'h8000_0004, 32'h0, 1'b0, 16'h0);
    check("ovf_cleared", dmem_rdata, 32'h208);
    step(1'b1, 1'b1, 32'h8000_0004, 32'h400, 1'b1, 16'h99);
    step(1'b1, 1'b0, 32'h8000_0004, 32'h0, 1'b0, 16'h0);
    check("ovf_set_wins", dmem_rdata, 32'h608);
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 1'b0, 32'h8000_0000, 32'h0, 1'b0, 16'h0);
      check($sformatf("drain%0d", i), dmem_rdata, 32'(i + 1));
    end
    step(1'b1, 1'b1, 32'h8000_0004, 32'h400, 1'b0, 16'h0);
    step(1'b1, 1'b1, 32'h8000_0008, 32'd100, 1'b0, 16'h0);
    step(1'b1, 1'b0, 32'h8000_0008, 32'h0, 1'b0, 16'h0);
    check("thresh_rd", dmem_rdata, ALERT ? 32'd100 : 32'h0);
    step(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 16'd100);
    check("alert_eq", {31'h0, alert}, 32'h0);
    step(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 16'd101);
    check("alert_gt", {31'h0, alert}, {31'h0, ALERT});
    step(1'b1, 1'b1, 32'h8000_0004, 32'h800, 1'b0, 16'h0);
    check("alert_clr", {31'h0, alert}, 32'h0);
    step(1'b1, 1'b1, 32'h8000_0004, 32'h800, 1'b1, 16'd200);
    check("alert_set_wins", {31'h0, alert}, {31'h0, ALERT});
    step(1'b1, 1'b0, 32'h8000_0004, 32'h0, 1'b0, 16'h0);
    check("alert_status", dmem_rdata, {20'h0, ALERT, 11'h3});
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 32'h8000_0000, 32'h0, 1'b0, 16'h0);
    step(1'b1, 1'b0, 32'h8000_0000, 32'h0, 1'b1, 16'h77);
    check("pushpop_empty", dmem_rdata, 32'h0);
    step(1'b1, 1'b0, 32'h8000_0004, 32'h0, 1'b0, 16'h0);
    check("pushpop_count", dmem_rdata, 32'h1);
    step(1'b1, 1'b0, 32'h8000_0000, 32'h0, 1'b0, 16'h0);
    check("pushpop_data", dmem_rdata, 32'h77);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 16'(i + 16'h40));
    step(1'b1, 1'b0, 32'h8000_0004, 32'h0, 1'b0, 16'h0);
    check("pre_reset_count", dmem_rdata, 32'h5);
    do_reset(1'b1, 32'h10);
    step(1'b1, 1'b0, 32'h8000_0004, 32'h0, 1'b0, 16'h0);
    check("post_reset_status", dmem_rdata, 32'h100);
    step(1'b1, 1'b0, 32'h8000_0008, 32'h0, 1'b0, 16'h0);
    check("post_reset_thresh", dmem_rdata, THR_RST);
    step(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 16'h0);
    check("post_reset_sram", dmem_rdata, 32'h8);
    for (int i = 0; i < 128; i++) step(1'b1, 1'b1, 32'(i * 4), $urandom, 1'b0, 16'h0);
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] a;
      logic [15:0] sd;
      if ($urandom_range(1, 0) == 1) a = $urandom & 32'h7FFF_FFFF;
      else a = 32'h8000_0000 | 32'($urandom_range(3, 0) << 2) | 32'($urandom_range(3, 0));
      sd = ($urandom_range(1, 0) == 1) ? 16'($urandom) : 16'($urandom_range(255, 0));
      step($urandom_range(3, 0) != 0, $urandom_range(2, 0) == 0, a, $urandom,
           $urandom_range(1, 0) == 1, sd);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
